// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiply sequencer.
package booth_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int PAIRS     = WIDTH_DEF / 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef logic [2:0] booth_sel_t;

  // Booth window codes {q[2i+1], q[2i], q[2i-1]}
  localparam booth_sel_t SEL_Z0  = 3'b000;
  localparam booth_sel_t SEL_P1A = 3'b001;
  localparam booth_sel_t SEL_P1B = 3'b010;
  localparam booth_sel_t SEL_P2  = 3'b011;
  localparam booth_sel_t SEL_N2  = 3'b100;
  localparam booth_sel_t SEL_N1A = 3'b101;
  localparam booth_sel_t SEL_N1B = 3'b110;
  localparam booth_sel_t SEL_Z1  = 3'b111;

endpackage

// File: rtl/booth_mul_seq_pp_sel.sv
// Combinational Booth partial-product selector: (sel, M) -> signed 2*WIDTH term.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]         sel_i,
  input  logic [WIDTH-1:0]   m_i,
  output logic [2*WIDTH-1:0] pp_o
);

  logic [2*WIDTH-1:0] mx_s;

  assign mx_s = {{WIDTH{m_i[WIDTH-1]}}, m_i};

  // Negations wrap mod 2^(2*WIDTH), which keeps -2M exact for the most-negative M.
  always_comb begin
    pp_o = {(2*WIDTH){1'b0}};
    case (sel_i)
      SEL_Z0, SEL_Z1:   pp_o = {(2*WIDTH){1'b0}};
      SEL_P1A, SEL_P1B: pp_o = mx_s;
      SEL_P2:           pp_o = mx_s << 1;
      SEL_N2:           pp_o = -(mx_s << 1);
      SEL_N1A, SEL_N1B: pp_o = -mx_s;
      default:          pp_o = {(2*WIDTH){1'b0}};
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one bit-pair per clock.
// Optional BOOTH_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all-0/all-1.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] q_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int NPAIRS = WIDTH / 2;
  localparam int CNT_W  = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam int PW     = 2 * WIDTH;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH:0]     qx_q, qx_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               ready_q, ready_d, busy_q, busy_d, done_q, done_d;

  logic [CNT_W:0]     sh_s;
  booth_sel_t         sel_s;
  logic [PW-1:0]      pp_s, sum_s;
  logic               last_s, early_s;

  assign sh_s   = {cnt_q, 1'b0};
  assign sel_s  = qx_q[sh_s +: 3];
  assign sum_s  = acc_q + (pp_s << sh_s);
  assign last_s = (cnt_q == CNT_W'(NPAIRS - 1));

  booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .sel_i (sel_s),
    .m_i   (m_q),
    .pp_o  (pp_s)
  );

`ifdef BOOTH_EARLY_TERM_EN
  // Arithmetic shift exposes qx[WIDTH:2*cnt]; uniform bits mean every remaining window selects 0.
  logic signed [WIDTH:0] qrem_s;
  assign qrem_s  = $signed(qx_q) >>> sh_s;
  assign early_s = (qrem_s == {(WIDTH+1){1'b0}}) || (qrem_s == {(WIDTH+1){1'b1}});
`else
  assign early_s = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      m_q     <= {WIDTH{1'b0}};
      qx_q    <= {(WIDTH+1){1'b0}};
      acc_q   <= {PW{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      qx_q    <= qx_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN; else state_d = S_IDLE;
      S_RUN:   if (early_s || last_s) state_d = S_DONE; else state_d = S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; HI/LO load on the edge entering DONE so they are valid with done_o.
  always_comb begin
    cnt_d = cnt_q;
    m_d   = m_q;
    qx_d  = qx_q;
    acc_d = acc_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          m_d   = m_i;
          qx_d  = {q_i, 1'b0};
          acc_d = {PW{1'b0}};
          cnt_d = {CNT_W{1'b0}};
        end else begin
          m_d   = m_q;
        end
      end
      S_RUN: begin
        if (early_s) begin
          {hi_d, lo_d} = acc_q;
        end else begin
          acc_d = sum_s;
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last_s) begin
            {hi_d, lo_d} = sum_s;
          end else begin
            hi_d = hi_q;
          end
        end
      end
      S_DONE:  cnt_d = cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  // Handshake outputs, registered from the next state.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: directed corner cases plus random operands vs. a 64-bit integer model.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] m_i = 32'd0;
  logic [31:0] q_i = 32'd0;
  logic        ready_o, busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] prod;
    int          cyc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  booth_mul_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .start_i (start_i),
    .m_i     (m_i),
    .q_i     (q_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  // Cycles from acceptance to done_o.
  function automatic int exp_lat(input logic [31:0] q);
`ifdef BOOTH_EARLY_TERM_EN
    logic [32:0] qx;
    logic        uni;
    qx = {q, 1'b0};
    for (int k = 0; k < 16; k++) begin
      uni = 1'b1;
      for (int b = 2 * k; b <= 32; b++) if (qx[b] != qx[32]) uni = 1'b0;
      if (uni) return k + 2;
    end
    return 17;
`else
    return 17 + 0 * int'(q[0]);
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done_o pops one expectation.
  always @(negedge clk) begin
    if (clr_n && done_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", {hi_o, lo_o}, e.prod);
        chk("latency", 64'(cyc - e.cyc), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready_o !== 1'b1) chk("ready_timeout", 64'd0, 64'd1);
    start_i = 1'b1;
    m_i = m;
    q_i = q;
    sb.push_back('{prod: exp, cyc: cyc, lat: exp_lat(q)});
    @(negedge clk);
    start_i = 1'b0;
    m_i = $urandom;
    q_i = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] corner [6];
    logic [31:0] m, q;
    logic        ok;
    corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h0000_0001; corner[5] = 32'h5555_5555;

    // 1: reset
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    clr_n = 1'b1;
    @(negedge clk);

    // 2: 7 x -3, handshake timing
    issue(32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
`ifndef BOOTH_EARLY_TERM_EN
    ok = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      if (ready_o !== 1'b0 || busy_o !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    chk("run_ready_low", 64'(ok), 64'd1);
    chk("ready_back", 64'(ready_o), 64'd1);
`endif
    drain();

    // 3: extreme operands
    issue(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    drain();
    issue(32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001);
    drain();

    // 4: start while busy is ignored; back-to-back start accepted
    issue(32'd1234, 32'd5678, 64'd7006652);
    repeat (4) @(negedge clk);
    start_i = 1'b1; m_i = 32'd99; q_i = 32'd99;
    @(negedge clk);
    start_i = 1'b0;
    issue(32'hFFFF_FF00, 32'd3, 64'hFFFF_FFFF_FFFF_FD00);
    drain();

    // 5: reset mid-run aborts
    issue(32'h0BAD_F00D, 32'h1234_5678, ref_mul(32'h0BAD_F00D, 32'h1234_5678));
    repeat (7) @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    sb.delete();
    chk("abort_ready", 64'(ready_o), 64'd1);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_done", 64'(done_o), 64'd0);
    chk("abort_hilo", {hi_o, lo_o}, 64'd0);
    repeat (20) @(negedge clk);
    issue(32'd100, 32'hFFFF_FFF6, 64'hFFFF_FFFF_FFFF_FC18);
    drain();

`ifdef BOOTH_EARLY_TERM_EN
    // 6: early termination corners
    issue(32'd123, 32'd0, 64'd0);
    drain();
    issue(32'd5, 32'd1, 64'd5);
    drain();
    issue(32'd5, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB);
    drain();
`endif

    // Random and corner operands
    for (int i = 0; i < 300; i++) begin
      m = $urandom;
      q = $urandom;
      if ($urandom_range(0, 3) == 0) m = corner[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) q = corner[$urandom_range(0, 5)];
      if ($urandom_range(0, 2) == 0) q = 32'($signed(q) >>> $urandom_range(0, 31));
      issue(m, q, ref_mul(m, q));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
